// File: rtl/epp_pkg.sv
// Shared definitions for the EPP register-file slave.
//   - FSM state encoding
//   - derived address map helpers (command base, DMA address bytes,
//     DMA data port, status register)
//   - status register bit positions
package epp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_DATA     = 3'd2,
    ST_WAIT_DMA = 3'd3,
    ST_HOLD     = 3'd4
  } epp_state_t;

  // Status byte layout: {timeout_flag, status_in[6:0]}
  localparam int STATUS_TIMEOUT_BIT = 7;
  localparam int STATUS_IN_W        = 7;

  function automatic int dma_addr_bytes(input int aw);
    return (aw + 7) / 8;
  endfunction

  function automatic int cmd_base(input int nregs);
    return nregs;
  endfunction

  function automatic int dma_addr0(input int nregs, input int ncmds);
    return nregs + ncmds;
  endfunction

  function automatic int dma_data_addr(input int nregs, input int ncmds, input int aw);
    return dma_addr0(nregs, ncmds) + dma_addr_bytes(aw);
  endfunction

  function automatic int status_addr(input int nregs, input int ncmds, input int aw);
    return dma_data_addr(nregs, ncmds, aw) + 1;
  endfunction

endpackage

// File: rtl/epp_sync.sv
// Two-flop synchroniser for one asynchronous EPP control line.
// Resets to 1 so that idle-high strobes look inactive out of reset.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input
//   o_q     : synchronised output
module epp_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/epp_regfile.sv
// EPP slave port for the blitter/GPU host interface.
// Address map: general registers, write-only command strobes, DMA address
// counter bytes (little-endian), DMA data port, status register.
//   clk, rst_n        : clock, asynchronous active-low reset
//   EppAstb/EppDstb   : host address/data strobes (active low, async)
//   EppWR             : 0 = host write, 1 = host read
//   EppWait           : handshake, high while the access is held
//   EppDB             : bidirectional data, driven only while EppWR=1
//   regs_flat         : general registers, register i at [8i+7:8i]
//   cmd_strobe/_data  : one-cycle command pulse and its data byte
//   busy, status_in   : GPU busy stall and status bits
//   dma_*             : byte DMA request/ack port with address counter
module epp_regfile
  import epp_pkg::*;
#(
  parameter int NUM_REGS = 12,
  parameter int NUM_CMDS = 2,
  parameter int DMA_AW   = 17,
  parameter int TIMEOUT  = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EppAstb,
  input  logic                  EppDstb,
  input  logic                  EppWR,
  output logic                  EppWait,
  inout  wire  [7:0]            EppDB,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic [NUM_CMDS-1:0]   cmd_strobe,
  output logic [7:0]            cmd_data,
  input  logic                  busy,
  input  logic [STATUS_IN_W-1:0] status_in,
  output logic                  dma_rd_req,
  output logic                  dma_wr_req,
  output logic [DMA_AW-1:0]     dma_addr,
  output logic [7:0]            dma_wr_data,
  input  logic                  dma_ack,
  input  logic [7:0]            dma_rd_data
);

  localparam int CMD_BASE  = cmd_base(NUM_REGS);
  localparam int DMA_AB    = dma_addr_bytes(DMA_AW);
  localparam int DMA_ADDR0 = dma_addr0(NUM_REGS, NUM_CMDS);
  localparam int DMA_DATA  = dma_data_addr(NUM_REGS, NUM_CMDS, DMA_AW);
  localparam int STATUS    = status_addr(NUM_REGS, NUM_CMDS, DMA_AW);
  localparam int PAD_W     = DMA_AB * 8;
  localparam int CNT_W     = $clog2(TIMEOUT + 1);

  localparam logic [PAD_W-1:0]  PAD_MASK = PAD_W'({DMA_AW{1'b1}});
  localparam logic [DMA_AW-1:0] ADDR_ONE = DMA_AW'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic w_astb_s, w_dstb_s, w_wr_s;

  epp_state_t        r_state;
  logic [7:0]        r_addr;
  logic [7:0]        r_drive;
  logic [7:0]        r_cmd_data;
  logic [7:0]        r_wbyte;
  logic [7:0]        r_regs [NUM_REGS];
  logic [NUM_CMDS-1:0] r_cmd_strobe;
  // DMA counter kept byte-padded; bits above DMA_AW are held at zero so
  // byte reads of the top address byte return 0 there.
  logic [PAD_W-1:0]  r_addr_pad;
  logic              r_timeout;
  logic              r_dma_rd;
  logic              r_req_done;
  logic              r_rd_req;
  logic              r_wr_req;
  logic [CNT_W-1:0]  r_cnt;

  logic [31:0]         w_addr32;
  logic                w_is_cmd, w_is_dma_addr, w_is_dma_data, w_is_status;
  logic [NUM_CMDS-1:0] w_cmd_onehot;
  logic [7:0]          w_rd_byte;
  logic [PAD_W-1:0]    w_pad_wr;
  logic [DMA_AW-1:0]   w_addr_inc;

  epp_sync u_sync_astb (.i_clk(clk), .i_rst_n(rst_n), .i_d(EppAstb), .o_q(w_astb_s));
  epp_sync u_sync_dstb (.i_clk(clk), .i_rst_n(rst_n), .i_d(EppDstb), .o_q(w_dstb_s));
  epp_sync u_sync_wr   (.i_clk(clk), .i_rst_n(rst_n), .i_d(EppWR),   .o_q(w_wr_s));

  assign w_addr32   = {24'd0, r_addr};
  assign w_addr_inc = r_addr_pad[DMA_AW-1:0] + ADDR_ONE;

  always_comb begin
    w_is_cmd      = (w_addr32 >= 32'(CMD_BASE)) && (w_addr32 < 32'(DMA_ADDR0));
    w_is_dma_addr = (w_addr32 >= 32'(DMA_ADDR0)) && (w_addr32 < 32'(DMA_DATA));
    w_is_dma_data = (w_addr32 == 32'(DMA_DATA));
    w_is_status   = (w_addr32 == 32'(STATUS));

    w_cmd_onehot = '0;
    for (int k = 0; k < NUM_CMDS; k++) begin
      if (w_addr32 == 32'(CMD_BASE + k)) w_cmd_onehot[k] = 1'b1;
    end

    // Read mux; commands and invalid addresses fall through to 0x00.
    w_rd_byte = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_addr32 == 32'(i)) w_rd_byte = r_regs[i];
    end
    for (int j = 0; j < DMA_AB; j++) begin
      if (w_addr32 == 32'(DMA_ADDR0 + j)) w_rd_byte = r_addr_pad[8*j +: 8];
    end
    if (w_is_status) w_rd_byte = {r_timeout, status_in};

    w_pad_wr = r_addr_pad;
    for (int j = 0; j < DMA_AB; j++) begin
      if (w_addr32 == 32'(DMA_ADDR0 + j)) w_pad_wr[8*j +: 8] = EppDB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_state == ST_DATA && !w_wr_s && w_addr32 == 32'(i)) r_regs[i] <= EppDB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= 8'h00;
      r_drive      <= 8'h00;
      r_cmd_data   <= 8'h00;
      r_wbyte      <= 8'h00;
      r_cmd_strobe <= '0;
      r_addr_pad   <= '0;
      r_timeout    <= 1'b0;
      r_dma_rd     <= 1'b0;
      r_req_done   <= 1'b0;
      r_rd_req     <= 1'b0;
      r_wr_req     <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_cmd_strobe <= '0;
      r_rd_req     <= 1'b0;
      r_wr_req     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_astb_s)      r_state <= ST_ADDR;
          else if (!w_dstb_s) r_state <= ST_DATA;
        end
        ST_ADDR: begin
          if (!w_wr_s) r_addr  <= EppDB;
          else         r_drive <= r_addr;
          r_state <= ST_HOLD;
        end
        ST_DATA: begin
          r_state <= ST_HOLD;
          if (w_is_dma_data) begin
            r_dma_rd   <= w_wr_s;
            r_wbyte    <= EppDB;
            r_cnt      <= '0;
            r_req_done <= 1'b0;
            r_state    <= ST_WAIT_DMA;
          end else if (w_wr_s) begin
            r_drive <= w_rd_byte;
            // The flag value is captured into r_drive on this same edge.
            if (w_is_status) r_timeout <= 1'b0;
          end else begin
            if (w_is_cmd) begin
              r_cmd_strobe <= w_cmd_onehot;
              r_cmd_data   <= EppDB;
            end
            if (w_is_dma_addr) r_addr_pad <= w_pad_wr & PAD_MASK;
          end
        end
        ST_WAIT_DMA: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (!r_req_done && !busy) begin
            r_req_done <= 1'b1;
            r_rd_req   <= r_dma_rd;
            r_wr_req   <= !r_dma_rd;
          end
          // An ack is only meaningful once the request has been issued;
          // an ack landing on the timeout cycle still completes normally.
          if (r_req_done && dma_ack) begin
            if (r_dma_rd) r_drive <= dma_rd_data;
            r_addr_pad <= PAD_W'(w_addr_inc);
            r_state    <= ST_HOLD;
          end else if (r_cnt == CNT_LAST) begin
            r_timeout <= 1'b1;
            if (r_dma_rd) r_drive <= 8'hFF;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_astb_s && w_dstb_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_flat[8*gi +: 8] = r_regs[gi];
    end
  endgenerate

  // Decoded from state so an asynchronous reset drops it immediately.
  assign EppWait     = (r_state == ST_HOLD);
  assign EppDB       = EppWR ? r_drive : 8'bzzzz_zzzz;
  assign cmd_strobe  = r_cmd_strobe;
  assign cmd_data    = r_cmd_data;
  assign dma_rd_req  = r_rd_req;
  assign dma_wr_req  = r_wr_req;
  assign dma_addr    = r_addr_pad[DMA_AW-1:0];
  assign dma_wr_data = r_wbyte;

endmodule

// File: tb/tb_epp_regfile.sv
module tb_epp_regfile;

  localparam int A_CMD1  = 13;
  localparam int A_DMA0  = 14;
  localparam int A_DMAD  = 17;
  localparam int A_STAT  = 18;
  localparam int A_INVAL = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic h_astb = 1'b1, h_dstb = 1'b1, h_wr = 1'b1, h_oe = 1'b0;
  logic [7:0] h_d = 8'h00;
  logic busy = 1'b0;
  logic [6:0] status_in = 7'h2A;
  logic ack0 = 1'b0;
  logic [7:0] rdd0 = 8'h00;

  wire astb0 = sel ? 1'b1 : h_astb;
  wire dstb0 = sel ? 1'b1 : h_dstb;
  wire astb1 = sel ? h_astb : 1'b1;
  wire dstb1 = sel ? h_dstb : 1'b1;
  wire [7:0] db0, db1;
  assign db0 = h_oe ? h_d : 8'bzzzz_zzzz;
  assign db1 = h_oe ? h_d : 8'bzzzz_zzzz;

  wire wait0, wait1;
  wire [95:0] regs0, regs1;
  wire [1:0] cs0, cs1;
  wire [7:0] cd0, cd1, wd0, wd1;
  wire rdreq0, wrreq0, rdreq1, wrreq1;
  wire [16:0] addr0, addr1;
  wire epp_wait = sel ? wait1 : wait0;
  wire [7:0] rdbus = sel ? db1 : db0;

  epp_regfile u0 (
    .clk(clk), .rst_n(rst_n), .EppAstb(astb0), .EppDstb(dstb0), .EppWR(h_wr),
    .EppWait(wait0), .EppDB(db0), .regs_flat(regs0), .cmd_strobe(cs0), .cmd_data(cd0),
    .busy(busy), .status_in(status_in), .dma_rd_req(rdreq0), .dma_wr_req(wrreq0),
    .dma_addr(addr0), .dma_wr_data(wd0), .dma_ack(ack0), .dma_rd_data(rdd0)
  );

  epp_regfile #(.TIMEOUT(15)) u1 (
    .clk(clk), .rst_n(rst_n), .EppAstb(astb1), .EppDstb(dstb1), .EppWR(h_wr),
    .EppWait(wait1), .EppDB(db1), .regs_flat(regs1), .cmd_strobe(cs1), .cmd_data(cd1),
    .busy(busy), .status_in(status_in), .dma_rd_req(rdreq1), .dma_wr_req(wrreq1),
    .dma_addr(addr1), .dma_wr_data(wd1), .dma_ack(1'b0), .dma_rd_data(8'h00)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [16:0] addr;
    logic [7:0]  data;
  } req_t;

  logic [7:0] exp_rd_q[$];
  req_t       exp_req_q[$];

  int req_cnt = 0;
  int strobe_cnt = 0;
  logic [1:0] last_strobe = 2'b00;
  int ack_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // DMA monitor for u0: scoreboard the requests and answer each with an
  // ack five clocks later.
  always @(negedge clk) begin
    req_t got;
    req_t e_req;
    if (ack0) ack0 = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) ack0 = 1'b1;
    end
    if (cs0 != 2'b00) begin
      strobe_cnt++;
      last_strobe = cs0;
    end
    if (rdreq0 || wrreq0) begin
      req_cnt++;
      got = '{rd: rdreq0, wr: wrreq0, addr: addr0, data: (rdreq0 ? 8'h00 : wd0)};
      chk("dma_req_pending", 128'(exp_req_q.size() != 0), 128'(1));
      if (exp_req_q.size() != 0) begin
        e_req = exp_req_q.pop_front();
        chk("dma_req", 128'(got), 128'(e_req));
      end
      ack_cnt = 5;
    end
  end

  task automatic xfer(input bit is_addr, input bit is_rd, input logic [7:0] wdat,
                      output logic [7:0] rdat, output int t_rise, output int t_fall);
    @(negedge clk);
    h_wr = is_rd;
    h_oe = !is_rd;
    h_d  = wdat;
    @(negedge clk);
    if (is_addr) h_astb = 1'b0;
    else         h_dstb = 1'b0;
    t_rise = 0;
    while (epp_wait !== 1'b1 && t_rise < 3000) begin
      @(negedge clk);
      t_rise++;
    end
    chk("wait_rise", 128'(epp_wait), 128'(1));
    rdat = rdbus;
    h_astb = 1'b1;
    h_dstb = 1'b1;
    t_fall = 0;
    while (epp_wait !== 1'b0 && t_fall < 100) begin
      @(negedge clk);
      t_fall++;
    end
    chk("wait_fall", 128'(epp_wait), 128'(0));
    h_oe = 1'b0;
    h_wr = 1'b1;
  endtask

  task automatic wr_addr(input logic [7:0] a);
    logic [7:0] r;
    int tr, tf;
    xfer(1'b1, 1'b0, a, r, tr, tf);
  endtask

  task automatic wr_data(input logic [7:0] d);
    logic [7:0] r;
    int tr, tf;
    xfer(1'b0, 1'b0, d, r, tr, tf);
  endtask

  task automatic rd_data(input string tag, input logic [7:0] e);
    logic [7:0] r;
    int tr, tf;
    exp_rd_q.push_back(e);
    xfer(1'b0, 1'b1, 8'h00, r, tr, tf);
    chk(tag, 128'(r), 128'(exp_rd_q.pop_front()));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic [95:0] snap;
    int tr, tf, r0, n, sc;

    repeat (3) @(negedge clk);
    chk("reset_regs", 128'(regs0), 128'(0));
    chk("reset_wait", 128'(wait0), 128'(0));
    chk("reset_cmd_strobe", 128'(cs0), 128'(0));
    chk("reset_cmd_data", 128'(cd0), 128'(0));
    chk("reset_dma_addr", 128'(addr0), 128'(0));
    chk("reset_dma_req", 128'({rdreq0, wrreq0}), 128'(0));
    chk("reset_drive", 128'(db0), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Register write/read with handshake latency
    wr_addr(8'h03);
    xfer(1'b0, 1'b0, 8'hA5, r, tr, tf);
    chk("lat_wait_rise", 128'(tr), 128'(4));
    chk("lat_wait_fall", 128'(tf), 128'(3));
    chk("reg3_write", 128'(regs0[31:24]), 128'(8'hA5));
    chk("regs_others_zero", 128'(regs0 & ~96'hFF00_0000), 128'(0));
    rd_data("reg3_read", 8'hA5);
    exp_rd_q.push_back(8'h03);
    xfer(1'b1, 1'b1, 8'h00, r, tr, tf);
    chk("addr_latch_read", 128'(r), 128'(exp_rd_q.pop_front()));
    wr_addr(8'd11);
    wr_data(8'h3C);
    chk("reg11_write", 128'(regs0[95:88]), 128'(8'h3C));
    rd_data("reg11_read", 8'h3C);

    // Command strobe
    wr_addr(8'(A_CMD1));
    sc = strobe_cnt;
    wr_data(8'h5A);
    chk("cmd_strobe_count", 128'(strobe_cnt - sc), 128'(1));
    chk("cmd_strobe_value", 128'(last_strobe), 128'(2'b10));
    chk("cmd_data", 128'(cd0), 128'(8'h5A));
    rd_data("cmd_read_zero", 8'h00);

    // DMA address counter, top byte masked above bit 16
    wr_addr(8'(A_DMA0));     wr_data(8'hFF);
    wr_addr(8'(A_DMA0 + 1)); wr_data(8'hFF);
    wr_addr(8'(A_DMA0 + 2)); wr_data(8'hFF);
    chk("dma_addr_set", 128'(addr0), 128'(17'h1FFFF));
    rd_data("dma_addr_hi_masked", 8'h01);

    // Two DMA writes across the address wrap
    wr_addr(8'(A_DMAD));
    exp_req_q.push_back('{rd: 1'b0, wr: 1'b1, addr: 17'h1FFFF, data: 8'h11});
    wr_data(8'h11);
    exp_req_q.push_back('{rd: 1'b0, wr: 1'b1, addr: 17'h00000, data: 8'h22});
    wr_data(8'h22);
    chk("dma_addr_after_wrap", 128'(addr0), 128'(17'h00001));
    chk("dma_req_all_seen", 128'(exp_req_q.size()), 128'(0));

    // DMA read stalled by busy
    busy = 1'b1;
    rdd0 = 8'hC3;
    r0 = req_cnt;
    exp_req_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 17'h00001, data: 8'h00});
    fork
      rd_data("dma_read_busy", 8'hC3);
      begin
        repeat (20) @(negedge clk);
        chk("no_req_while_busy", 128'(req_cnt), 128'(r0));
        busy = 1'b0;
      end
    join
    chk("one_req_after_busy", 128'(req_cnt), 128'(r0 + 1));
    chk("dma_addr_after_read", 128'(addr0), 128'(17'h00002));

    // Status register without timeout; writes are ignored
    wr_addr(8'(A_STAT));
    rd_data("status_clean", 8'h2A);
    wr_data(8'hFF);
    rd_data("status_after_write", 8'h2A);

    // Invalid address
    wr_addr(8'(A_INVAL));
    snap = regs0;
    sc = strobe_cnt;
    xfer(1'b0, 1'b0, 8'h77, r, tr, tf);
    chk("invalid_wait_rise", 128'(tr), 128'(4));
    chk("invalid_regs_unchanged", 128'(regs0), 128'(snap));
    chk("invalid_no_strobe", 128'(strobe_cnt), 128'(sc));
    chk("invalid_dma_addr", 128'(addr0), 128'(17'h00002));
    rd_data("invalid_read_zero", 8'h00);

    // Timeout on the TIMEOUT=15 instance
    sel = 1'b1;
    wr_addr(8'(A_DMAD));
    rd_data("timeout_read_ff", 8'hFF);
    chk("timeout_addr_unchanged", 128'(addr1), 128'(17'h00000));
    wr_addr(8'(A_STAT));
    rd_data("status_timeout_set", 8'hAA);
    rd_data("status_timeout_clr", 8'h2A);
    sel = 1'b0;

    // Asynchronous reset while holding EppWait
    @(negedge clk);
    h_wr = 1'b1;
    h_dstb = 1'b0;
    n = 0;
    while (wait0 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached", 128'(wait0), 128'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_hold_wait", 128'(wait0), 128'(0));
    chk("reset_mid_hold_regs", 128'(regs0), 128'(0));
    chk("reset_mid_hold_cmd_data", 128'(cd0), 128'(0));
    chk("reset_mid_hold_dma_addr", 128'(addr0), 128'(0));
    h_dstb = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wr_addr(8'h03);
    rd_data("reg3_after_reset", 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/epp_regfile.md
Name: epp_regfile

Overview:
- Parametrised EPP slave port: second-generation host register interface for the blitter/GPU.
- Bridges the Digilent-style EPP bus (EppAstb/EppDstb/EppWR/EppWait/EppDB) to:
  - a configurable bank of byte registers;
  - one-cycle command strobes;
  - a byte-wide DMA port with address auto-increment and access timeout.
- Adds over the first generation: strobe synchronisation, a full EPP handshake (wait held until the strobe is released), deterministic handling of invalid addresses, and a busy-stall.

Parameters:
- NUM_REGS, 12, number of general 8-bit read/write registers at addresses 0..NUM_REGS-1.
- NUM_CMDS, 2, number of write-only command addresses, starting at NUM_REGS.
- DMA_AW, 17, width of the DMA byte address counter.
- TIMEOUT, 1023, max cycles spent in WAIT_DMA before abort (≥1).

Derived addresses:
- CMD_BASE = NUM_REGS.
- DMA_ADDR0 = NUM_REGS+NUM_CMDS, with DMA_AW/8 rounded up consecutive bytes, little-endian.
- DMA_DATA = next address.
- STATUS = next address.
- All others are invalid.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- EppAstb  in  1  address strobe, active low, asynchronous to clk
- EppDstb  in  1  data strobe, active low, asynchronous to clk
- EppWR  in  1  0 = host write, 1 = host read
- EppWait  out  1  handshake to host
- EppDB  inout  8  bidirectional data bus; driven only when EppWR=1
- regs_flat  out  NUM_REGS*8  register i occupies bits [8i+7:8i]
- cmd_strobe  out  NUM_CMDS  one-cycle pulse on write to CMD_BASE+k
- cmd_data  out  8  byte written with the last command, stable until the next command write
- busy  in  1  GPU busy; DMA accesses stall while high
- status_in  in  7  GPU status bits
- dma_rd_req  out  1  one-cycle read request
- dma_wr_req  out  1  one-cycle write request
- dma_addr  out  DMA_AW  current DMA byte address
- dma_wr_data  out  8  write byte, valid with dma_wr_req
- dma_ack  in  1  single-cycle completion for either request
- dma_rd_data  in  8  read byte, valid with dma_ack

Behaviour:
- Reset values (async, rst_n=0):
  - all registers, address latch, cmd_data, dma_addr, EppDB drive value and timeout flag = 0;
  - EppWait=0; cmd_strobe, dma_rd_req and dma_wr_req = 0;
  - FSM returns to IDLE.
  - A reset mid-transfer abandons the transfer and issues no strobes.
- Synchronisation: EppAstb, EppDstb and EppWR each pass through a 2-flop synchroniser. The FSM acts on the synchronised copies. EppDB is sampled in the same cycle the synchronised strobe is seen low; the host holds data for the whole strobe.
- FSM states: IDLE, ADDR, DATA, WAIT_DMA, HOLD.
  - IDLE:
    - sync Astb low → ADDR;
    - else sync Dstb low → DATA;
    - if both are low, Astb wins.
  - ADDR:
    - write: address latch ← EppDB;
    - read: drive value ← address latch;
    - → HOLD.
  - DATA, by address:
    - reg i: write stores the byte; read returns it.
    - CMD_BASE+k, write: cmd_strobe[k]=1 for exactly one cycle, cmd_data ← byte. A read returns 0x00.
    - DMA_ADDR bytes: read/write the counter byte; bits above DMA_AW read as 0.
    - DMA_DATA: latch direction and write byte → WAIT_DMA.
    - STATUS, read: returns {timeout_flag, status_in}, then clears timeout_flag on the same cycle. Writes are ignored.
    - Invalid address: write ignored, read returns 0x00.
    - All cases except DMA_DATA → HOLD.
  - WAIT_DMA:
    - While busy=1, no request is issued.
    - On the first cycle with busy=0, the request pulses for one cycle.
    - On dma_ack: a read latches dma_rd_data as the drive value; dma_addr increments modulo 2^DMA_AW (wraps to 0); → HOLD.
    - Cycle counter starts on entry. When it reaches TIMEOUT without ack:
      - set timeout_flag; a read returns 0xFF;
      - dma_addr is not incremented;
      - → HOLD.
      - A late ack after that is ignored.
  - HOLD: EppWait=1 until both sync strobes are high, then EppWait=0 → IDLE. EppWait is 0 in all other states.
- Latency:
  - Register access: EppWait rises 4 clk after the strobe falls (2 sync + decode + HOLD).
  - EppWait falls 3 clk after the strobe rises.
- EppDB drive value persists until next overwritten. EppDB is hi-Z whenever raw EppWR=0.

Decomposition:
- Shared package epp_pkg:
  - FSM state enum;
  - derived address localparam functions (CMD_BASE, DMA_ADDR0, DMA_DATA, STATUS);
  - status bit index constants.
- One sub-module: epp_sync, a 2-flop synchroniser with a reset value of 1, instantiated per strobe/WR bit.

Test Plan:
- Reset, then address write 0x03 and data write 0xA5:
  - regs_flat[31:24]=0xA5;
  - EppWait high until Dstb released, then low within 3 clk;
  - data read at 0x03 returns 0xA5.
- Data write 0x5A to CMD_BASE+1 → cmd_strobe=2'b10 for exactly one cycle, cmd_data=0x5A, no other strobe.
- dma_addr set to 0x1FFFF (DMA_AW=17), then two DMA_DATA writes 0x11, 0x22 with ack after 5 clk:
  - dma_wr_req pulses with addr 0x1FFFF, then 0x00000;
  - dma_addr ends at 0x00001.
- busy=1 for 20 clk during a DMA_DATA read: no dma_rd_req while busy. After busy falls, req pulses once; ack with 0xC3 → host reads 0xC3.
- DMA read with no ack, TIMEOUT=15:
  - read returns 0xFF; dma_addr unchanged;
  - STATUS read returns bit7=1; next STATUS read returns bit7=0.
- Invalid address (STATUS+1): write leaves all regs unchanged, read returns 0x00, EppWait still completes. Assert rst_n mid-HOLD → EppWait=0 immediately.
